// File: rtl/conv_result_writer.sv
// conv_result_writer
// Captures result tiles from the 3x3 float16 convolution unit, optionally
// clamps negative words to +0 (ReLU), and writes each tile word by word into
// the output feature-map memory at raster addresses across the output frame.
// Two tile slots absorb one tile of write backpressure.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             latch config, clear slots/counters/flags, abort drain
//   base_addr         address of output pixel (0,0)
//   out_width         frame width in words (multiple of PARA_Y)
//   out_height        frame height in rows (multiple of PARA_X)
//   relu_en           clamp negative words to +0 at capture
//   result_ready      tile-valid pulse; result_buffer holds the tile
//   wr_ready          memory accepts the presented write
//   wr_en/addr/data   registered write port
//   busy              any slot valid
//   frame_done        pulse the cycle after the final word of a frame
//   overflow          sticky: a tile was dropped
module conv_result_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int PARA_X     = 3,
   parameter int PARA_Y     = 3,
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ADDR_WIDTH-1:0]               base_addr,
   input  logic [DIM_WIDTH-1:0]                out_width,
   input  logic [DIM_WIDTH-1:0]                out_height,
   input  logic                                relu_en,
   input  logic                                result_ready,
   input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] result_buffer,
   input  logic                                wr_ready,
   output logic                                wr_en,
   output logic [ADDR_WIDTH-1:0]               wr_addr,
   output logic [DATA_WIDTH-1:0]               wr_data,
   output logic                                busy,
   output logic                                frame_done,
   output logic                                overflow
);

   localparam int N  = PARA_X * PARA_Y;
   localparam int TW = N * DATA_WIDTH;
   localparam int WW = (N > 1) ? $clog2(N) : 1;
   localparam int YW = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;
   localparam logic [WW-1:0]         W_LAST = WW'(N - 1);
   localparam logic [YW-1:0]         Y_LAST = YW'(PARA_Y - 1);
   localparam logic [DIM_WIDTH:0]    PY_D   = (DIM_WIDTH+1)'(PARA_Y);
   localparam logic [DIM_WIDTH:0]    PX_D   = (DIM_WIDTH+1)'(PARA_X);
   localparam logic [ADDR_WIDTH-1:0] PX_A   = ADDR_WIDTH'(PARA_X);

   logic [ADDR_WIDTH-1:0] cfg_base;
   logic [DIM_WIDTH-1:0]  cfg_width, cfg_height;
   logic                  cfg_relu;

   logic [TW-1:0]         slot_data [2];
   logic [1:0]            slot_valid;
   logic                  head;

   logic [WW-1:0]         w_idx;
   logic [YW-1:0]         y_idx;
   logic [ADDR_WIDTH-1:0] x_off;
   logic [ADDR_WIDTH-1:0] tile_base, row_base;
   logic [DIM_WIDTH-1:0]  col, row;

   logic                  accept, last, capture, drop, cap_slot, head_n, frame_end;
   logic [1:0]            valid_after, valid_n;
   logic [TW-1:0]         relu_tile, sel_tile;
   logic [WW-1:0]         w_n;
   logic [YW-1:0]         y_n;
   logic [ADDR_WIDTH-1:0] x_off_n, tile_base_n, row_base_n, addr_n;
   logic [DIM_WIDTH-1:0]  col_n, row_n;
   logic [DIM_WIDTH:0]    col_nx, row_nx;
   logic                  wr_en_n;
   logic [DATA_WIDTH-1:0] data_n;

   always_comb begin
      accept = wr_en & wr_ready;
      last   = accept && (w_idx == W_LAST);

      for (int j = 0; j < N; j++) begin
         relu_tile[j*DATA_WIDTH +: DATA_WIDTH] =
            (cfg_relu && result_buffer[j*DATA_WIDTH + DATA_WIDTH - 1]) ?
            '0 : result_buffer[j*DATA_WIDTH +: DATA_WIDTH];
      end

      // A slot freed by the final accept this cycle is reusable immediately.
      valid_after = slot_valid;
      if (last) valid_after[head] = 1'b0;
      cap_slot = valid_after[0];
      capture  = result_ready && !(valid_after[0] && valid_after[1]);
      drop     = result_ready &&  (valid_after[0] && valid_after[1]);
      valid_n  = valid_after;
      if (capture) valid_n[cap_slot] = 1'b1;

      // Oldest slot: flip after a finished tile; a capture into an otherwise
      // empty buffer becomes the oldest.
      head_n = last ? ~head : head;
      if (capture && !valid_after[~cap_slot]) head_n = cap_slot;

      w_n     = w_idx;
      y_n     = y_idx;
      x_off_n = x_off;
      if (last) begin
         w_n     = '0;
         y_n     = '0;
         x_off_n = '0;
      end else if (accept) begin
         w_n = w_idx + 1'b1;
         if (y_idx == Y_LAST) begin
            y_n     = '0;
            x_off_n = x_off + ADDR_WIDTH'(cfg_width);
         end else begin
            y_n = y_idx + 1'b1;
         end
      end

      col_nx      = {1'b0, col} + PY_D;
      row_nx      = {1'b0, row} + PX_D;
      col_n       = col;
      row_n       = row;
      row_base_n  = row_base;
      tile_base_n = tile_base;
      frame_end   = 1'b0;
      if (last) begin
         if (col_nx == {1'b0, cfg_width}) begin
            col_n = '0;
            if (row_nx == {1'b0, cfg_height}) begin
               frame_end   = 1'b1;
               row_n       = '0;
               row_base_n  = cfg_base;
               tile_base_n = cfg_base;
            end else begin
               row_n       = row_nx[DIM_WIDTH-1:0];
               row_base_n  = row_base + PX_A * ADDR_WIDTH'(cfg_width);
               tile_base_n = row_base_n;
            end
         end else begin
            col_n       = col_nx[DIM_WIDTH-1:0];
            tile_base_n = row_base + ADDR_WIDTH'(col_nx[DIM_WIDTH-1:0]);
         end
      end

      // Outputs are registered, so present the next cycle's word now.
      sel_tile = (capture && (cap_slot == head_n)) ? relu_tile : slot_data[head_n];
      wr_en_n  = valid_n[head_n];
      data_n   = wr_en_n ? sel_tile[int'(w_n)*DATA_WIDTH +: DATA_WIDTH] : '0;
      addr_n   = tile_base_n + x_off_n + ADDR_WIDTH'(y_n);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_base   <= '0;
         cfg_width  <= '0;
         cfg_height <= '0;
         cfg_relu   <= 1'b0;
         slot_data[0] <= '0;
         slot_data[1] <= '0;
         slot_valid <= '0;
         head       <= 1'b0;
         w_idx      <= '0;
         y_idx      <= '0;
         x_off      <= '0;
         tile_base  <= '0;
         row_base   <= '0;
         col        <= '0;
         row        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else if (start) begin
         cfg_base   <= base_addr;
         cfg_width  <= out_width;
         cfg_height <= out_height;
         cfg_relu   <= relu_en;
         slot_valid <= '0;
         head       <= 1'b0;
         w_idx      <= '0;
         y_idx      <= '0;
         x_off      <= '0;
         tile_base  <= base_addr;
         row_base   <= base_addr;
         col        <= '0;
         row        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (capture) slot_data[cap_slot] <= relu_tile;
         slot_valid <= valid_n;
         head       <= head_n;
         w_idx      <= w_n;
         y_idx      <= y_n;
         x_off      <= x_off_n;
         tile_base  <= tile_base_n;
         row_base   <= row_base_n;
         col        <= col_n;
         row        <= row_n;
         wr_en      <= wr_en_n;
         wr_addr    <= addr_n;
         wr_data    <= data_n;
         busy       <= |valid_n;
         frame_done <= last && frame_end;
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;

   localparam int TW = 144;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   base_addr;
   logic [9:0]    out_width, out_height;
   logic          relu_en;
   logic          result_ready;
   logic [TW-1:0] result_buffer;
   logic          wr_ready;
   logic          wr_en;
   logic [15:0]   wr_addr;
   logic [15:0]   wr_data;
   logic          busy, frame_done, overflow;

   int passed = 0;
   int total  = 0;

   conv_result_writer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .out_width(out_width), .out_height(out_height), .relu_en(relu_en),
      .result_ready(result_ready), .result_buffer(result_buffer),
      .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [TW-1:0] mk_tile(input logic [15:0] b, input logic [15:0] s);
      logic [TW-1:0] t;
      for (int j = 0; j < 9; j++) t[j*16 +: 16] = 16'(b + 16'(j) * s);
      return t;
   endfunction

   // Expected address of word w of a tile based at tb with frame width wd.
   function automatic logic [15:0] exp_addr(input logic [15:0] tb, input int w, input int wd);
      return 16'(int'(tb) + (w / 3) * wd + (w % 3));
   endfunction

   // Driving helpers: called at a negedge, return at a negedge.
   task automatic do_start(input logic [15:0] b, input int w, input int h, input logic r);
      base_addr = b; out_width = 10'(w); out_height = 10'(h); relu_en = r;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_tile(input logic [TW-1:0] t);
      result_buffer = t;
      result_ready  = 1'b1;
      @(negedge clk);
      result_ready  = 1'b0;
   endtask

   task automatic test_reset;
      total++;
      if ({wr_en, wr_addr, wr_data, busy, frame_done, overflow} !== 35'd0)
         $display("FAIL reset_outputs: got %b required 0",
                  {wr_en, wr_addr, wr_data, busy, frame_done, overflow});
      else passed++;
   endtask

   task automatic test_single_tile;
      logic [15:0] ea, ed;
      do_start(16'h0100, 6, 3, 1'b0);
      wr_ready = 1'b1;
      pulse_tile(mk_tile(16'h3C00, 16'h0190));
      for (int i = 0; i < 9; i++) begin
         ea = exp_addr(16'h0100, i, 6);
         ed = 16'(16'h3C00 + i * 16'h0190);
         total++;
         if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== ed)
            $display("FAIL single_word%0d: en=%b addr=%h data=%h required en=1 addr=%h data=%h",
                     i, wr_en, wr_addr, wr_data, ea, ed);
         else passed++;
         @(negedge clk);
      end
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL single_idle: en=%b busy=%b fd=%b required 0 0 0", wr_en, busy, frame_done);
      else passed++;
   endtask

   task automatic test_frame_walk;
      logic [15:0] ea;
      pulse_tile(mk_tile(16'h0010, 16'h0001));
      for (int i = 0; i < 9; i++) begin
         ea = exp_addr(16'h0103, i, 6);
         total++;
         if (wr_en !== 1'b1 || wr_addr !== ea || frame_done !== 1'b0)
            $display("FAIL walk_word%0d: en=%b addr=%h fd=%b required en=1 addr=%h fd=0",
                     i, wr_en, wr_addr, frame_done, ea);
         else passed++;
         @(negedge clk);
      end
      total++;
      if (frame_done !== 1'b1)
         $display("FAIL walk_frame_done: got %b required 1", frame_done);
      else passed++;
      @(negedge clk);
      total++;
      if (frame_done !== 1'b0)
         $display("FAIL walk_frame_done_pulse: got %b required 0", frame_done);
      else passed++;
      pulse_tile(mk_tile(16'h0020, 16'h0001));
      for (int i = 0; i < 9; i++) begin
         ea = exp_addr(16'h0100, i, 6);
         total++;
         if (wr_en !== 1'b1 || wr_addr !== ea)
            $display("FAIL wrap_word%0d: en=%b addr=%h required en=1 addr=%h", i, wr_en, wr_addr, ea);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_relu;
      logic [TW-1:0] t;
      logic [15:0] in_w [9];
      logic [15:0] exp_w [9];
      in_w  = '{16'hBC00, 16'h8000, 16'hFC00, 16'h7E00, 16'h3C00, 16'hFE00, 16'h8001, 16'h0001, 16'h7C00};
      exp_w = '{16'h0000, 16'h0000, 16'h0000, 16'h7E00, 16'h3C00, 16'h0000, 16'h0000, 16'h0001, 16'h7C00};
      for (int j = 0; j < 9; j++) t[j*16 +: 16] = in_w[j];
      do_start(16'h0100, 6, 3, 1'b1);
      pulse_tile(t);
      for (int i = 0; i < 9; i++) begin
         total++;
         if (wr_en !== 1'b1 || wr_data !== exp_w[i])
            $display("FAIL relu_word%0d: en=%b data=%h required en=1 data=%h", i, wr_en, wr_data, exp_w[i]);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] ea, ed;
      int t;
      int bad;
      do_start(16'h0100, 6, 3, 1'b0);
      wr_ready = 1'b0;
      pulse_tile(mk_tile(16'h1000, 16'h0001));
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            result_buffer = mk_tile(16'h2000, 16'h0001);
            result_ready  = 1'b1;
         end else result_ready = 1'b0;
         @(negedge clk);
         total++;
         if ({wr_en, wr_addr, wr_data, busy, overflow} !== {1'b1, 16'h0100, 16'h1000, 1'b1, 1'b0}) begin
            $display("FAIL bp_stall%0d: en=%b addr=%h data=%h busy=%b ovf=%b required 1 0100 1000 1 0",
                     i, wr_en, wr_addr, wr_data, busy, overflow);
            bad++;
         end else passed++;
      end
      pulse_tile(mk_tile(16'h3000, 16'h0001));
      total++;
      if (overflow !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 16'h0100)
         $display("FAIL bp_overflow: ovf=%b en=%b addr=%h required 1 1 0100", overflow, wr_en, wr_addr);
      else passed++;
      wr_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         t  = i / 9;
         ea = exp_addr(16'(16'h0100 + 3 * t), i % 9, 6);
         ed = 16'((t == 0 ? 16'h1000 : 16'h2000) + (i % 9));
         total++;
         if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== ed)
            $display("FAIL bp_drain%0d: en=%b addr=%h data=%h required en=1 addr=%h data=%h",
                     i, wr_en, wr_addr, wr_data, ea, ed);
         else passed++;
         @(negedge clk);
      end
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1)
         $display("FAIL bp_after: en=%b busy=%b ovf=%b required 0 0 1", wr_en, busy, overflow);
      else passed++;
   endtask

   task automatic test_boundary_capture;
      logic [15:0] ea, ed;
      int t;
      do_start(16'h0200, 12, 6, 1'b0);
      wr_ready = 1'b1;
      pulse_tile(mk_tile(16'h4000, 16'h0001));
      for (int i = 0; i < 27; i++) begin
         if (i == 2) begin
            result_buffer = mk_tile(16'h5000, 16'h0001);
            result_ready  = 1'b1;
         end else if (i == 8) begin
            result_buffer = mk_tile(16'h6000, 16'h0001);
            result_ready  = 1'b1;
         end else result_ready = 1'b0;
         t  = i / 9;
         ea = exp_addr(16'(16'h0200 + 3 * t), i % 9, 12);
         ed = 16'(16'h4000 + 16'h1000 * t + (i % 9));
         total++;
         if (wr_en !== 1'b1 || wr_addr !== ea || wr_data !== ed || overflow !== 1'b0)
            $display("FAIL boundary%0d: en=%b addr=%h data=%h ovf=%b required en=1 addr=%h data=%h ovf=0",
                     i, wr_en, wr_addr, wr_data, overflow, ea, ed);
         else passed++;
         @(negedge clk);
      end
      result_ready = 1'b0;
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0)
         $display("FAIL boundary_after: en=%b busy=%b ovf=%b required 0 0 0", wr_en, busy, overflow);
      else passed++;
   endtask

   task automatic test_abort;
      int seen;
      do_start(16'h0100, 6, 3, 1'b0);
      wr_ready = 1'b0;
      pulse_tile(mk_tile(16'h1000, 16'h0001));
      pulse_tile(mk_tile(16'h2000, 16'h0001));
      pulse_tile(mk_tile(16'h3000, 16'h0001));
      wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (overflow !== 1'b1 || wr_en !== 1'b1)
         $display("FAIL abort_pre: ovf=%b en=%b required 1 1", overflow, wr_en);
      else passed++;
      do_start(16'h0300, 6, 3, 1'b0);
      total++;
      if (wr_en !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0)
         $display("FAIL abort_stop: en=%b ovf=%b busy=%b required 0 0 0", wr_en, overflow, busy);
      else passed++;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (wr_en) seen++;
      end
      total++;
      if (seen != 0)
         $display("FAIL abort_no_resume: writes=%0d required 0", seen);
      else passed++;
      // start and result_ready together: tile discarded, no overflow
      result_buffer = mk_tile(16'h7000, 16'h0001);
      result_ready  = 1'b1;
      do_start(16'h0300, 6, 3, 1'b0);
      result_ready  = 1'b0;
      @(negedge clk);
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0)
         $display("FAIL start_wins: en=%b busy=%b ovf=%b required 0 0 0", wr_en, busy, overflow);
      else passed++;
      pulse_tile(mk_tile(16'h7100, 16'h0001));
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h0300 || wr_data !== 16'h7100)
         $display("FAIL restart_first: en=%b addr=%h data=%h required 1 0300 7100", wr_en, wr_addr, wr_data);
      else passed++;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_async_reset;
      do_start(16'h0100, 6, 3, 1'b0);
      wr_ready = 1'b0;
      pulse_tile(mk_tile(16'h1000, 16'h0001));
      pulse_tile(mk_tile(16'h2000, 16'h0001));
      pulse_tile(mk_tile(16'h3000, 16'h0001));
      wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (wr_en !== 1'b1 || overflow !== 1'b1 || busy !== 1'b1)
         $display("FAIL rst_pre: en=%b ovf=%b busy=%b required 1 1 1", wr_en, overflow, busy);
      else passed++;
      #2 rst = 1'b0;
      #1;
      total++;
      if ({wr_en, wr_addr, wr_data, busy, frame_done, overflow} !== 35'd0)
         $display("FAIL rst_async: got %b required 0",
                  {wr_en, wr_addr, wr_data, busy, frame_done, overflow});
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (wr_en !== 1'b0 || busy !== 1'b0)
         $display("FAIL rst_no_resume: en=%b busy=%b required 0 0", wr_en, busy);
      else passed++;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = '0; out_width = '0; out_height = '0;
      relu_en = 1'b0; result_ready = 1'b0; result_buffer = '0; wr_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset;
      test_single_tile;
      test_frame_walk;
      test_relu;
      test_backpressure;
      test_boundary_capture;
      test_abort;
      test_async_reset;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Downstream stage of the 3x3 parallel float16 convolution unit. It captures each `PARA_X*PARA_Y` result tile when the unit pulses `result_ready`, and optionally applies ReLU. It then writes the tile word by word into the output feature-map memory, generating raster addresses across the whole output frame. A two-slot buffer absorbs one tile of write backpressure without stalling the convolution unit.

## Interface
- `DATA_WIDTH`, 16, float16 word width
- `PARA_X`, 3, tile rows (MAC groups)
- `PARA_Y`, 3, tile columns (MACs per group)
- `ADDR_WIDTH`, 16, output memory address width
- `DIM_WIDTH`, 10, width of frame dimension inputs
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; latches config, clears all state
- `base_addr`  in  ADDR_WIDTH  address of output pixel (0,0)
- `out_width`  in  DIM_WIDTH  frame width in words; multiple of PARA_Y, nonzero
- `out_height`  in  DIM_WIDTH  frame height in rows; multiple of PARA_X, nonzero
- `relu_en`  in  1  1: clamp negative results to +0
- `result_ready`  in  1  tile valid pulse from conv unit
- `result_buffer`  in  PARA_X*PARA_Y*DATA_WIDTH  tile; word j at bits [16j+15:16j], j = x*PARA_Y + y
- `wr_ready`  in  1  memory accepts write this cycle
- `wr_en`  out  1  write request
- `wr_addr`  out  ADDR_WIDTH  write address
- `wr_data`  out  DATA_WIDTH  write data
- `busy`  out  1  any slot valid
- `frame_done`  out  1  one-cycle pulse after last word of last tile is accepted
- `overflow`  out  1  sticky: a tile was dropped

## Operation
- Config registers: `base_addr`, `out_width`, `out_height`, `relu_en` are latched on `start`. `start` clears slots, counters, `overflow`, and `frame_done`. A `start` pulse while busy aborts the in-flight drain with no further writes.
- Slots: two entries, each holding a tile plus a valid bit. Capture writes the lower-index free slot, in arrival order. Drain always serves the oldest slot.
- Capture rule: on `result_ready`, a tile is accepted if a slot is free, or if the draining slot has its last word accepted in the same cycle. Otherwise the tile is dropped and `overflow` is set to 1. `overflow` holds until `start` or reset.
- ReLU: applied at capture. If `relu_en` and bit 15 = 1, the word becomes 16'h0000. This covers -0, negative normals, subnormals, -inf, and negative NaN. Otherwise the word passes unchanged.
- Drain: word index w runs 0..PARA_X*PARA_Y-1, with x = w / PARA_Y and y = w % PARA_Y.
  - `wr_addr` = tile_base + x*out_width + y, computed modulo 2^ADDR_WIDTH.
  - w advances only on `wr_en && wr_ready`.
  - `wr_en`, `wr_addr`, and `wr_data` hold stable while `wr_ready` = 0.
- Tile walk: tile_base starts at `base_addr`, with col = 0 and row = 0.
  - After each tile: col += PARA_Y.
  - If col reaches `out_width`: col = 0, row += PARA_X, and row_base += PARA_X*out_width.
  - tile_base = row_base + col.
- Frame end: when row reaches `out_height` after a tile, `frame_done` pulses. Counters then wrap to `base_addr` for the next frame.

## Timing
- Reset values: `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `frame_done` = 0, `overflow` = 0. Config registers, counters, and slots reset to 0.
- Latency: `result_ready` in cycle t with the buffer empty gives `wr_en` = 1, word 0, in cycle t+1. All outputs are registered.
- Throughput: one word per cycle with `wr_ready` held high, so a tile drains in PARA_X*PARA_Y = 9 cycles. The conv unit produces a tile no faster than every K*K+1 cycles, so K = 3 never overflows without backpressure.
- Back-to-back tiles: word 0 of the next slot follows the last word of the current slot with no gap cycle.
- `busy` = OR of slot valid bits, registered.
- `frame_done` is asserted the cycle after the final accept.
- Simultaneous `start` and `result_ready`: `start` wins and the tile is discarded. `overflow` is not set.
- Reset mid-drain: all outputs drop to their reset values immediately. No partial-tile resume.

## Test plan
- Single tile: `start` with base 0x100, width 6, height 3, relu 0; one tile with words 0x3C00..0x4880 and `wr_ready` = 1. Expect 9 consecutive writes at 0x100, 101, 102, 106, 107, 108, 10C, 10D, 10E, starting the cycle after `result_ready`.
- Frame walk: second tile goes to 0x103, 104, 105, 109, … Expect `frame_done` once, one cycle after the write to 0x111. The third tile restarts at 0x100.
- ReLU: relu_en = 1, tile containing 0xBC00, 0x8000, 0xFC00, 0x7E00, 0x3C00. Expect written data 0, 0, 0, 0x7E00, 0x3C00.
- Backpressure: hold `wr_ready` = 0 for 20 cycles while 2 tiles arrive. Expect outputs stable, `busy` = 1, `overflow` = 0. A third tile then sets `overflow` = 1; release drains exactly 18 words in order.
- Boundary capture: `result_ready` coincides with the last-word accept while the other slot is full. Expect the tile accepted with no overflow.
- Abort/reset: `start` mid-drain stops `wr_en` in the next cycle and clears `overflow`. Async `rst` low mid-write drops all outputs to 0 with no clock edge required.
